// File: rtl/mc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mc_ctrl
// Description : Multi-cycle MIPS control FSM. Sequences PC, IR, GPR, ALU, DM
//               and NPC through FETCH/DCD/EXE/MEM/WB/BR/JMP states and drives
//               the single-cycle decoder's control encodings, gated per state.
//               Optional macro MC_PERF_EN adds instr_cnt/cycle_cnt counters.
// Revision    : 1.0 - initial release
// ============================================================================
module mc_ctrl #(
    parameter int ST_W = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [5:0]      opcode,
    input  logic [5:0]      funct,
    input  logic            zero,
    output logic            PCWr,
    output logic            IRWr,
    output logic            RegWrite,
    output logic            MemWrite,
    output logic [2:0]      NpcSel,
    output logic [1:0]      RegDst,
    output logic [1:0]      wd_sel,
    output logic [1:0]      ExtOp,
    output logic            AluSrc,
    output logic [3:0]      AluCtrl,
    output logic [ST_W-1:0] state
`ifdef MC_PERF_EN
    ,
    output logic [31:0]     instr_cnt,
    output logic [31:0]     cycle_cnt
`endif
);

    // State encodings
    localparam logic [ST_W-1:0] c_stFetch = ST_W'(0);
    localparam logic [ST_W-1:0] c_stDcd   = ST_W'(1);
    localparam logic [ST_W-1:0] c_stExe   = ST_W'(2);
    localparam logic [ST_W-1:0] c_stMemRd = ST_W'(3);
    localparam logic [ST_W-1:0] c_stMemWr = ST_W'(4);
    localparam logic [ST_W-1:0] c_stWbAlu = ST_W'(5);
    localparam logic [ST_W-1:0] c_stWbMem = ST_W'(6);
    localparam logic [ST_W-1:0] c_stBr    = ST_W'(7);
    localparam logic [ST_W-1:0] c_stJmp   = ST_W'(8);

    // ALU operation encodings
    localparam logic [3:0] c_aluAddu = 4'b0000;
    localparam logic [3:0] c_aluSubu = 4'b0001;
    localparam logic [3:0] c_aluOr   = 4'b0010;
    localparam logic [3:0] c_aluBb   = 4'b0011;
    localparam logic [3:0] c_aluAa   = 4'b0100;
    localparam logic [3:0] c_aluAdd  = 4'b0101;
    localparam logic [3:0] c_aluLt   = 4'b0110;

    logic [ST_W-1:0] r_state;
    logic [ST_W-1:0] w_nextState;

    // Instruction decode
    logic w_isR, w_isAddu, w_isSubu, w_isSlt, w_isJr;
    logic w_isOri, w_isLui, w_isLw, w_isSw, w_isAddi, w_isAddiu;
    logic w_isBeq, w_isJ, w_isJal, w_isExeOp, w_isJmpOp;

    assign w_isR     = (opcode == 6'b000000);
    assign w_isAddu  = w_isR && (funct == 6'b100001);
    assign w_isSubu  = w_isR && (funct == 6'b100011);
    assign w_isSlt   = w_isR && (funct == 6'b101010);
    assign w_isJr    = w_isR && (funct == 6'b001000);
    assign w_isOri   = (opcode == 6'b001101);
    assign w_isLui   = (opcode == 6'b001111);
    assign w_isLw    = (opcode == 6'b100011);
    assign w_isSw    = (opcode == 6'b101011);
    assign w_isAddi  = (opcode == 6'b001000);
    assign w_isAddiu = (opcode == 6'b001001);
    assign w_isBeq   = (opcode == 6'b000100);
    assign w_isJ     = (opcode == 6'b000010);
    assign w_isJal   = (opcode == 6'b000011);
    assign w_isExeOp = w_isAddu | w_isSubu | w_isSlt | w_isOri | w_isLui |
                       w_isLw | w_isSw | w_isAddi | w_isAddiu;
    assign w_isJmpOp = w_isJ | w_isJal | w_isJr;

    // ALU configuration for the current instruction, used from EXE through writeback
    logic       w_aluSrc;
    logic [1:0] w_extOp;
    logic [3:0] w_aluCtrl;

    // Select ALU operand source, immediate extension and ALU op from the decode
    always_comb begin
        w_aluSrc  = 1'b1;
        w_extOp   = 2'b01;
        w_aluCtrl = c_aluAddu;
        if (w_isR) begin
            w_aluSrc  = 1'b0;
            w_extOp   = 2'b00;
            w_aluCtrl = w_isSubu ? c_aluSubu : (w_isSlt ? c_aluLt : c_aluAddu);
        end else if (w_isOri) begin
            w_extOp   = 2'b00;
            w_aluCtrl = c_aluOr;
        end else if (w_isLui) begin
            w_extOp   = 2'b10;
            w_aluCtrl = c_aluBb;
        end else if (w_isAddi) begin
            w_aluCtrl = c_aluAdd;
        end
    end

    // State register; reset abandons any instruction in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_stFetch;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state and per-state control outputs; everything is forced low in reset
    always_comb begin
        w_nextState = c_stFetch;
        PCWr        = 1'b0;
        IRWr        = 1'b0;
        RegWrite    = 1'b0;
        MemWrite    = 1'b0;
        NpcSel      = 3'b000;
        RegDst      = 2'b00;
        wd_sel      = 2'b00;
        ExtOp       = 2'b00;
        AluSrc      = 1'b0;
        AluCtrl     = 4'b0000;
        case (r_state)
            c_stFetch: begin
                w_nextState = c_stDcd;
                IRWr        = 1'b1;
                PCWr        = 1'b1;
            end
            c_stDcd: begin
                if (w_isBeq)        w_nextState = c_stBr;
                else if (w_isJmpOp) w_nextState = c_stJmp;
                else if (w_isExeOp) w_nextState = c_stExe;
                else                w_nextState = c_stFetch;
            end
            c_stExe: begin
                AluSrc  = w_aluSrc;
                ExtOp   = w_extOp;
                AluCtrl = w_aluCtrl;
                if (w_isLw)      w_nextState = c_stMemRd;
                else if (w_isSw) w_nextState = c_stMemWr;
                else             w_nextState = c_stWbAlu;
            end
            c_stMemRd: begin
                AluSrc      = w_aluSrc;
                ExtOp       = w_extOp;
                AluCtrl     = w_aluCtrl;
                w_nextState = c_stWbMem;
            end
            c_stMemWr: begin
                AluSrc   = w_aluSrc;
                ExtOp    = w_extOp;
                AluCtrl  = w_aluCtrl;
                MemWrite = 1'b1;
            end
            c_stWbAlu: begin
                AluSrc   = w_aluSrc;
                ExtOp    = w_extOp;
                AluCtrl  = w_aluCtrl;
                RegWrite = 1'b1;
                RegDst   = w_isR ? 2'b01 : 2'b00;
            end
            c_stWbMem: begin
                AluSrc   = w_aluSrc;
                ExtOp    = w_extOp;
                AluCtrl  = w_aluCtrl;
                RegWrite = 1'b1;
                wd_sel   = 2'b01;
            end
            c_stBr: begin
                AluCtrl = c_aluSubu;
                NpcSel  = 3'b001;
                PCWr    = zero;
            end
            c_stJmp: begin
                PCWr = 1'b1;
                if (w_isJr) begin
                    NpcSel  = 3'b100;
                    AluCtrl = c_aluAa;
                end else if (w_isJal) begin
                    NpcSel   = 3'b010;
                    RegWrite = 1'b1;
                    RegDst   = 2'b10;
                    wd_sel   = 2'b10;
                end else begin
                    NpcSel = 3'b011;
                end
            end
            default: w_nextState = c_stFetch;
        endcase
        if (rst) begin
            PCWr     = 1'b0;
            IRWr     = 1'b0;
            RegWrite = 1'b0;
            MemWrite = 1'b0;
            NpcSel   = 3'b000;
            RegDst   = 2'b00;
            wd_sel   = 2'b00;
            ExtOp    = 2'b00;
            AluSrc   = 1'b0;
            AluCtrl  = 4'b0000;
        end
    end

    assign state = r_state;

`ifdef MC_PERF_EN
    logic w_enterFetch;
    assign w_enterFetch = (r_state != c_stFetch) && (w_nextState == c_stFetch);

    // Free-running cycle counter and retired-instruction counter (wrap naturally)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_cnt <= 32'd0;
            instr_cnt <= 32'd0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (w_enterFetch) begin
                instr_cnt <= instr_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_mc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mc_ctrl
// Description : Scoreboard bench for mc_ctrl. Stimulus queues the expected
//               per-cycle control trace of each instruction from a reference
//               model; a negedge monitor pops and compares every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mc_ctrl;

    localparam int ST_W = 4;

    typedef struct packed {
        logic [3:0] st;
        logic       pcWr;
        logic       irWr;
        logic       regWr;
        logic       memWr;
        logic [2:0] npc;
        logic [1:0] regDst;
        logic [1:0] wdSel;
        logic [1:0] extOp;
        logic       aluSrc;
        logic [3:0] aluCtrl;
    } rec_t;

    logic            clk;
    logic            rst;
    logic [5:0]      opcode;
    logic [5:0]      funct;
    logic            zero;
    logic            PCWr, IRWr, RegWrite, MemWrite, AluSrc;
    logic [2:0]      NpcSel;
    logic [1:0]      RegDst, wd_sel, ExtOp;
    logic [3:0]      AluCtrl;
    logic [ST_W-1:0] state;
`ifdef MC_PERF_EN
    logic [31:0]     instr_cnt, cycle_cnt;
`endif

    int   vectors = 0;
    int   errors  = 0;
    rec_t expQ[$];

    mc_ctrl #(.ST_W(ST_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .opcode   (opcode),
        .funct    (funct),
        .zero     (zero),
        .PCWr     (PCWr),
        .IRWr     (IRWr),
        .RegWrite (RegWrite),
        .MemWrite (MemWrite),
        .NpcSel   (NpcSel),
        .RegDst   (RegDst),
        .wd_sel   (wd_sel),
        .ExtOp    (ExtOp),
        .AluSrc   (AluSrc),
        .AluCtrl  (AluCtrl),
        .state    (state)
`ifdef MC_PERF_EN
        ,
        .instr_cnt(instr_cnt),
        .cycle_cnt(cycle_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Monitor: one expected record per cycle, sampled mid-cycle
    always @(negedge clk) begin
        rec_t e;
        rec_t a;
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            a = {state, PCWr, IRWr, RegWrite, MemWrite, NpcSel, RegDst,
                 wd_sel, ExtOp, AluSrc, AluCtrl};
            vectors++;
            if (a !== e) begin
                errors++;
                $display("FAIL trace t=%0t op=%b fn=%b: got st=%0d pc=%b ir=%b rw=%b mw=%b npc=%b rd=%b wd=%b ext=%b src=%b alu=%b, exp st=%0d pc=%b ir=%b rw=%b mw=%b npc=%b rd=%b wd=%b ext=%b src=%b alu=%b",
                         $time, opcode, funct,
                         a.st, a.pcWr, a.irWr, a.regWr, a.memWr, a.npc, a.regDst, a.wdSel, a.extOp, a.aluSrc, a.aluCtrl,
                         e.st, e.pcWr, e.irWr, e.regWr, e.memWr, e.npc, e.regDst, e.wdSel, e.extOp, e.aluSrc, e.aluCtrl);
            end
        end
    end

    function automatic rec_t mk(input int st);
        rec_t r;
        r    = '0;
        r.st = 4'(st);
        return r;
    endfunction

    // Reference model: expected per-cycle trace of one instruction, starting at FETCH
    task automatic pushTrace(input logic [5:0] op, input logic [5:0] fn,
                             input logic z, output int n);
        string kind;
        rec_t  r;
        rec_t  alu;
        bit    isR;
        isR = (op == 6'd0);
        case (op)
            6'b000000: case (fn)
                6'b100001: kind = "addu";
                6'b100011: kind = "subu";
                6'b101010: kind = "slt";
                6'b001000: kind = "jr";
                default:   kind = "nop";
            endcase
            6'b001101: kind = "ori";
            6'b001111: kind = "lui";
            6'b100011: kind = "lw";
            6'b101011: kind = "sw";
            6'b001000: kind = "addi";
            6'b001001: kind = "addiu";
            6'b000100: kind = "beq";
            6'b000010: kind = "j";
            6'b000011: kind = "jal";
            default:   kind = "nop";
        endcase
        // ALU settings that hold from EXE until writeback completes
        alu = '0;
        case (kind)
            "addu":  begin alu.aluSrc = 0; alu.extOp = 2'b00; alu.aluCtrl = 4'd0; end
            "subu":  begin alu.aluSrc = 0; alu.extOp = 2'b00; alu.aluCtrl = 4'd1; end
            "slt":   begin alu.aluSrc = 0; alu.extOp = 2'b00; alu.aluCtrl = 4'd6; end
            "ori":   begin alu.aluSrc = 1; alu.extOp = 2'b00; alu.aluCtrl = 4'd2; end
            "lui":   begin alu.aluSrc = 1; alu.extOp = 2'b10; alu.aluCtrl = 4'd3; end
            "addi":  begin alu.aluSrc = 1; alu.extOp = 2'b01; alu.aluCtrl = 4'd5; end
            default: begin alu.aluSrc = 1; alu.extOp = 2'b01; alu.aluCtrl = 4'd0; end
        endcase
        r = mk(0); r.pcWr = 1; r.irWr = 1; expQ.push_back(r);
        expQ.push_back(mk(1));
        n = 2;
        if (kind == "beq") begin
            r = mk(7); r.aluCtrl = 4'd1; r.npc = 3'b001; r.pcWr = z;
            expQ.push_back(r); n = 3;
        end else if (kind == "j" || kind == "jal" || kind == "jr") begin
            r = mk(8); r.pcWr = 1;
            if (kind == "j") r.npc = 3'b011;
            if (kind == "jr") begin r.npc = 3'b100; r.aluCtrl = 4'd4; end
            if (kind == "jal") begin
                r.npc = 3'b010; r.regWr = 1; r.regDst = 2'b10; r.wdSel = 2'b10;
            end
            expQ.push_back(r); n = 3;
        end else if (kind != "nop") begin
            r = alu; r.st = 4'd2; expQ.push_back(r);
            if (kind == "lw") begin
                r = alu; r.st = 4'd3; expQ.push_back(r);
                r = alu; r.st = 4'd6; r.regWr = 1; r.wdSel = 2'b01; expQ.push_back(r);
                n = 5;
            end else if (kind == "sw") begin
                r = alu; r.st = 4'd4; r.memWr = 1; expQ.push_back(r);
                n = 4;
            end else begin
                r = alu; r.st = 4'd5; r.regWr = 1; r.regDst = isR ? 2'b01 : 2'b00;
                expQ.push_back(r);
                n = 4;
            end
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic runInstr(input logic [5:0] op, input logic [5:0] fn, input logic z);
        int n;
        opcode = op;
        funct  = fn;
        zero   = z;
        pushTrace(op, fn, z, n);
        cycles(n);
    endtask

    // Hold reset for two sampled cycles, then release just after a clock edge
    task automatic resetPulse();
        rst = 1'b1;
        expQ.push_back(mk(0));
        expQ.push_back(mk(0));
        cycles(2);
        rst = 1'b0;
    endtask

    task automatic pickRandom(output logic [5:0] op, output logic [5:0] fn);
        int sel;
        sel = $urandom_range(0, 15);
        fn  = 6'($urandom);
        case (sel)
            0:  begin op = 6'b000000; fn = 6'b100001; end
            1:  begin op = 6'b000000; fn = 6'b100011; end
            2:  begin op = 6'b000000; fn = 6'b101010; end
            3:  begin op = 6'b000000; fn = 6'b001000; end
            4:  op = 6'b001101;
            5:  op = 6'b001111;
            6:  op = 6'b100011;
            7:  op = 6'b101011;
            8:  op = 6'b001000;
            9:  op = 6'b001001;
            10: op = 6'b000100;
            11: op = 6'b000010;
            12: op = 6'b000011;
            13: op = 6'b111111;
            14: op = 6'($urandom);
            default: op = 6'b000000;
        endcase
    endtask

    initial begin
        logic [5:0] op;
        logic [5:0] fn;
        rst    = 1'b1;
        opcode = 6'd0;
        funct  = 6'd0;
        zero   = 1'b0;
        @(posedge clk);
        #1;
        resetPulse();

        // Directed instructions
        runInstr(6'b001101, 6'h15, 1'b0);   // ori
        runInstr(6'b100011, 6'h00, 1'b0);   // lw
        runInstr(6'b101011, 6'h3f, 1'b1);   // sw
        runInstr(6'b000100, 6'h00, 1'b1);   // beq taken
        runInstr(6'b000100, 6'h00, 1'b0);   // beq not taken
        runInstr(6'b000011, 6'h00, 1'b0);   // jal
        runInstr(6'b000000, 6'b001000, 1'b0); // jr
        runInstr(6'b000010, 6'h00, 1'b0);   // j
        runInstr(6'b111111, 6'h00, 1'b0);   // unsupported

        // addu abandoned by an asynchronous reset in EXE
        opcode = 6'b000000;
        funct  = 6'b100001;
        expQ.push_back({4'd0, 1'b1, 1'b1, 20'd0} >> 6);
        expQ.pop_back();
        begin
            rec_t r;
            r = mk(0); r.pcWr = 1; r.irWr = 1; expQ.push_back(r);
            expQ.push_back(mk(1));
        end
        cycles(2);
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if (state !== 4'd0 || PCWr !== 1'b0 || IRWr !== 1'b0 ||
            RegWrite !== 1'b0 || MemWrite !== 1'b0) begin
            errors++;
            $display("FAIL asyncRst: got st=%0d pc=%b ir=%b rw=%b mw=%b, exp st=0 and strobes 0",
                     state, PCWr, IRWr, RegWrite, MemWrite);
        end
        expQ.push_back(mk(0));
        cycles(1);
        expQ.push_back(mk(0));
        cycles(1);
        rst = 1'b0;

        // Randomized instruction stream
        for (int i = 0; i < 200; i++) begin
            pickRandom(op, fn);
            runInstr(op, fn, 1'($urandom));
        end

`ifdef MC_PERF_EN
        resetPulse();
        for (int i = 0; i < 4; i++) begin
            runInstr(6'b001101, 6'($urandom), 1'($urandom));
        end
        vectors++;
        if (instr_cnt !== 32'd4) begin
            errors++;
            $display("FAIL instr_cnt: got %0d, exp 4", instr_cnt);
        end
        vectors++;
        if (cycle_cnt !== 32'd16) begin
            errors++;
            $display("FAIL cycle_cnt: got %0d, exp 16", cycle_cnt);
        end
`endif

        cycles(2);
        vectors++;
        if (expQ.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending, exp 0", expQ.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire
